// File: rtl/sram_arbiter_if.sv
// Fetch port, data port and SRAM pad signals of the SRAM arbiter.
// slave = arbiter view, master = requesters plus pad side.
interface sram_arbiter_if #(
   parameter int SRAM_AW = 20
);
   logic               IF_REQ;
   logic [31:0]        IF_ADDR;
   logic               IF_ACK;
   logic [31:0]        IF_RDATA;
   logic               IF_STALL;

   logic               MEM_REQ;
   logic               MEM_WE;
   logic [3:0]         MEM_BE_N;
   logic [31:0]        MEM_ADDR;
   logic [31:0]        MEM_WDATA;
   logic               MEM_ACK;
   logic [31:0]        MEM_RDATA;
   logic               MEM_STALL;

   logic [SRAM_AW-1:0] SRAM_ADDR;
   logic               SRAM_CE_N;
   logic               SRAM_OE_N;
   logic               SRAM_WE_N;
   logic [3:0]         SRAM_BE_N;
   logic [31:0]        SRAM_DQ_O;
   logic               SRAM_DQ_OE;
   logic [31:0]        SRAM_DQ_I;

   modport slave (
      input  IF_REQ, IF_ADDR,
      input  MEM_REQ, MEM_WE, MEM_BE_N, MEM_ADDR, MEM_WDATA,
      input  SRAM_DQ_I,
      output IF_ACK, IF_RDATA, IF_STALL,
      output MEM_ACK, MEM_RDATA, MEM_STALL,
      output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N, SRAM_DQ_O, SRAM_DQ_OE
   );

   modport master (
      output IF_REQ, IF_ADDR,
      output MEM_REQ, MEM_WE, MEM_BE_N, MEM_ADDR, MEM_WDATA,
      output SRAM_DQ_I,
      input  IF_ACK, IF_RDATA, IF_STALL,
      input  MEM_ACK, MEM_RDATA, MEM_STALL,
      input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N, SRAM_DQ_O, SRAM_DQ_OE
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the fetch (read-only) and data ports; REQ->ACK is ACCESS_CYCLES+1.
// No skid: a requester holds REQ and stalls until its one-cycle ACK; MEM wins ties unless IF is starved.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4,
   parameter int SRAM_AW       = 20
) (
   input logic           CLK,
   input logic           RST,
   sram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] CNT_LAST   = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t             state_q, state_d;
   logic               owner_mem_q, owner_mem_d;
   logic               is_wr_q, is_wr_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         starve_q, starve_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [3:0]         be_n_q, be_n_d;
   logic [31:0]        dq_o_q, dq_o_d;
   logic               dq_oe_q, dq_oe_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        mem_rdata_q, mem_rdata_d;
   logic               grant_if;
   logic               if_ack, mem_ack;

   always_comb begin
      state_d     = state_q;
      owner_mem_d = owner_mem_q;
      is_wr_d     = is_wr_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      addr_d      = addr_q;
      be_n_d      = be_n_q;
      dq_o_d      = dq_o_q;
      dq_oe_d     = dq_oe_q;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      grant_if    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!bus.IF_REQ) starve_d = '0;
            if (bus.IF_REQ || bus.MEM_REQ) begin
               grant_if = bus.IF_REQ && (!bus.MEM_REQ || starve_q == STARVE_MAX);
               state_d  = S_ACCESS;
               cnt_d    = '0;
               ce_n_d   = 1'b0;
               if (grant_if) begin
                  owner_mem_d = 1'b0;
                  is_wr_d     = 1'b0;
                  addr_d      = bus.IF_ADDR[SRAM_AW+1:2];
                  be_n_d      = 4'b0000;
                  oe_n_d      = 1'b0;
                  we_n_d      = 1'b1;
                  dq_oe_d     = 1'b0;
                  starve_d    = '0;
               end else begin
                  owner_mem_d = 1'b1;
                  is_wr_d     = bus.MEM_WE;
                  addr_d      = bus.MEM_ADDR[SRAM_AW+1:2];
                  be_n_d      = bus.MEM_BE_N;
                  oe_n_d      = bus.MEM_WE;
                  we_n_d      = !bus.MEM_WE;
                  dq_oe_d     = bus.MEM_WE;
                  if (bus.MEM_WE) dq_o_d = bus.MEM_WDATA;
                  if (bus.IF_REQ && starve_q < STARVE_MAX) starve_d = starve_q + 4'd1;
               end
            end
         end

         S_ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               if (is_wr_q) begin
                  // Recovery cycle: release WE_N but keep chip, address and data stable.
                  we_n_d = 1'b1;
               end else begin
                  ce_n_d = 1'b1;
                  oe_n_d = 1'b1;
                  if (owner_mem_q) mem_rdata_d = bus.SRAM_DQ_I;
                  else             if_rdata_d  = bus.SRAM_DQ_I;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            be_n_d  = 4'b1111;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         owner_mem_q <= 1'b0;
         is_wr_q     <= 1'b0;
         cnt_q       <= '0;
         starve_q    <= '0;
         addr_q      <= '0;
         be_n_q      <= 4'b1111;
         dq_o_q      <= '0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_mem_q <= owner_mem_d;
         is_wr_q     <= is_wr_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         addr_q      <= addr_d;
         be_n_q      <= be_n_d;
         dq_o_q      <= dq_o_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_ack  = (state_q == S_DONE) && !owner_mem_q;
   assign mem_ack = (state_q == S_DONE) &&  owner_mem_q;

   assign bus.IF_ACK     = if_ack;
   assign bus.MEM_ACK    = mem_ack;
   assign bus.IF_RDATA   = if_rdata_q;
   assign bus.MEM_RDATA  = mem_rdata_q;
   assign bus.IF_STALL   = bus.IF_REQ & ~if_ack;
   assign bus.MEM_STALL  = bus.MEM_REQ & ~mem_ack;
   assign bus.SRAM_ADDR  = addr_q;
   assign bus.SRAM_CE_N  = ce_n_q;
   assign bus.SRAM_OE_N  = oe_n_q;
   assign bus.SRAM_WE_N  = we_n_q;
   assign bus.SRAM_BE_N  = be_n_q;
   assign bus.SRAM_DQ_O  = dq_o_q;
   assign bus.SRAM_DQ_OE = dq_oe_q;

   // Byte-offset and above-array address bits have no meaning for a word-wide SRAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.IF_ADDR[1:0], bus.IF_ADDR[31:SRAM_AW+2],
                               bus.MEM_ADDR[1:0], bus.MEM_ADDR[31:SRAM_AW+2]};
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vectors, hand sequences and a randomized run
// against a transaction-level schedule model; a second instance uses ACCESS_CYCLES=1.
module tb_sram_arbiter;
   localparam int AC = 2;
   localparam int SL = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   sram_arbiter_if #(.SRAM_AW(20)) b0 ();
   sram_arbiter_if #(.SRAM_AW(20)) b1 ();

   sram_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL), .SRAM_AW(20)) u_dut (
      .CLK(CLK), .RST(RST), .bus(b0));
   sram_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(SL), .SRAM_AW(20)) u_dut1 (
      .CLK(CLK), .RST(RST), .bus(b1));

   // Simple SRAM models: byte-masked write on each clock with CE_N and WE_N low.
   logic [31:0] mem0 [0:1023];
   logic [31:0] mem1 [0:1023];
   logic        pl0_en = 1'b0, pl1_en = 1'b0;
   logic [9:0]  pl0_addr = '0, pl1_addr = '0;
   logic [31:0] pl0_dat = '0, pl1_dat = '0;

   always @(posedge CLK) begin
      if (pl0_en) mem0[pl0_addr] <= pl0_dat;
      else if (!b0.SRAM_CE_N && !b0.SRAM_WE_N)
         for (int i = 0; i < 4; i++)
            if (!b0.SRAM_BE_N[i]) mem0[b0.SRAM_ADDR[9:0]][8*i +: 8] <= b0.SRAM_DQ_O[8*i +: 8];
   end
   always @(posedge CLK) begin
      if (pl1_en) mem1[pl1_addr] <= pl1_dat;
      else if (!b1.SRAM_CE_N && !b1.SRAM_WE_N)
         for (int i = 0; i < 4; i++)
            if (!b1.SRAM_BE_N[i]) mem1[b1.SRAM_ADDR[9:0]][8*i +: 8] <= b1.SRAM_DQ_O[8*i +: 8];
   end
   assign b0.SRAM_DQ_I = (!b0.SRAM_CE_N && !b0.SRAM_OE_N) ? mem0[b0.SRAM_ADDR[9:0]] : 32'h0;
   assign b1.SRAM_DQ_I = (!b1.SRAM_CE_N && !b1.SRAM_OE_N) ? mem1[b1.SRAM_ADDR[9:0]] : 32'h0;

   typedef struct {
      bit          is_mem;
      bit          we;
      logic [3:0]  be_n;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          preload;
      logic [31:0] pre_dat;
      logic [19:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_val;
      logic [31:0] exp_if_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      b0.IF_REQ = 0; b0.IF_ADDR = '0; b0.MEM_REQ = 0; b0.MEM_WE = 0;
      b0.MEM_BE_N = 4'hF; b0.MEM_ADDR = '0; b0.MEM_WDATA = '0;
      b1.IF_REQ = 0; b1.IF_ADDR = '0; b1.MEM_REQ = 0; b1.MEM_WE = 0;
      b1.MEM_BE_N = 4'hF; b1.MEM_ADDR = '0; b1.MEM_WDATA = '0;
   endtask

   task automatic run_vec(input vec_t v);
      int         ack_cyc, oe_cnt, we_cnt, oth_ack;
      logic [9:0] w;
      w = v.addr[11:2];
      ack_cyc = -1; oe_cnt = 0; we_cnt = 0; oth_ack = 0;
      @(posedge CLK); #1;
      if (v.preload) begin
         pl0_en = 1; pl0_addr = w; pl0_dat = v.pre_dat;
         @(posedge CLK); #1;
         pl0_en = 0;
      end
      b0.MEM_BE_N = v.be_n; b0.MEM_WE = v.we; b0.MEM_WDATA = v.wdata;
      if (v.is_mem) begin b0.MEM_REQ = 1; b0.MEM_ADDR = v.addr; end
      else          begin b0.IF_REQ  = 1; b0.IF_ADDR  = v.addr; end
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         if (c == 0) check("stall_c0", v.is_mem ? b0.MEM_STALL : b0.IF_STALL, 1);
         if (c == 1) begin
            check("sram_addr", b0.SRAM_ADDR, v.exp_addr);
            check("sram_be_n", b0.SRAM_BE_N, v.exp_be);
            check("ce_n_access", b0.SRAM_CE_N, 0);
            check("dq_oe_access", b0.SRAM_DQ_OE, v.we);
         end
         if (!b0.SRAM_OE_N) oe_cnt++;
         if (!b0.SRAM_WE_N) we_cnt++;
         if (v.is_mem ? b0.IF_ACK : b0.MEM_ACK) oth_ack++;
         if ((v.is_mem ? b0.MEM_ACK : b0.IF_ACK) && ack_cyc < 0) begin
            ack_cyc = c;
            if (v.we) begin
               check("rec_we_n", b0.SRAM_WE_N, 1);
               check("rec_ce_n", b0.SRAM_CE_N, 0);
               check("rec_dq_oe", b0.SRAM_DQ_OE, 1);
               check("rec_dq_o", b0.SRAM_DQ_O, v.wdata);
               check("rec_be_n", b0.SRAM_BE_N, v.exp_be);
            end else begin
               check("done_ce_n", b0.SRAM_CE_N, 1);
            end
         end
         @(posedge CLK); #1;
         if (ack_cyc >= 0) begin b0.IF_REQ = 0; b0.MEM_REQ = 0; end
      end
      check("ack_cycle", ack_cyc, AC + 1);
      check("strobe_cycles", v.we ? we_cnt : oe_cnt, AC);
      check("other_ack", oth_ack, 0);
      if (v.we)          check("mem_word", mem0[w], v.exp_val);
      else if (v.is_mem) check("mem_rdata", b0.MEM_RDATA, v.exp_val);
      else               check("if_rdata", b0.IF_RDATA, v.exp_val);
      check("if_rdata_hold", b0.IF_RDATA, v.exp_if_rd);
   endtask

   // Schedule model: an access granted in cycle g acks in g+AC+1, and the
   // arbiter is free to grant again in g+AC+2.
   task automatic random_phase(input int ncyc);
      logic [31:0] ref_mem [0:63];
      bit          ifp, memp, busy, own_mem, mwe, win_if, eia, ema;
      logic [31:0] ia, ma, mwd, exp_ird, exp_mrd;
      logic [3:0]  mbe;
      int          starve, ack_at;
      @(posedge CLK); #1;
      idle_inputs();
      RST = 0;
      @(posedge CLK); #1;
      RST = 1;
      for (int i = 0; i < 64; i++) ref_mem[i] = mem0[i];
      ifp = 0; memp = 0; busy = 0; own_mem = 0; mwe = 0; starve = 0; ack_at = 0;
      ia = '0; ma = '0; mwd = '0; mbe = '0; exp_ird = '0; exp_mrd = '0;
      for (int k = 0; k < ncyc; k++) begin
         if (!ifp && $urandom_range(0, 1) == 1) begin
            ifp = 1;
            ia  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         end
         if (!memp && $urandom_range(0, 1) == 1) begin
            memp = 1;
            ma   = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            mwe  = 1'($urandom_range(0, 1));
            mbe  = 4'($urandom_range(0, 15));
            mwd  = $urandom;
         end
         b0.IF_REQ = ifp; b0.IF_ADDR = ia;
         b0.MEM_REQ = memp; b0.MEM_ADDR = ma; b0.MEM_WE = mwe;
         b0.MEM_BE_N = mbe; b0.MEM_WDATA = mwd;
         @(negedge CLK);
         if (!busy) begin
            if (!ifp) starve = 0;
            if (ifp || memp) begin
               win_if = ifp && (!memp || starve == SL);
               if (win_if) starve = 0;
               else if (ifp && starve < SL) starve++;
               busy    = 1;
               own_mem = !win_if;
               ack_at  = k + AC + 1;
            end
         end
         eia = busy && !own_mem && k == ack_at;
         ema = busy &&  own_mem && k == ack_at;
         check("rnd_if_ack", b0.IF_ACK, eia);
         check("rnd_mem_ack", b0.MEM_ACK, ema);
         check("rnd_if_stall", b0.IF_STALL, ifp && !eia);
         check("rnd_mem_stall", b0.MEM_STALL, memp && !ema);
         if (eia) begin exp_ird = ref_mem[ia[7:2]]; ifp = 0; end
         if (ema) begin
            if (mwe) begin
               for (int b = 0; b < 4; b++)
                  if (!mbe[b]) ref_mem[ma[7:2]][8*b +: 8] = mwd[8*b +: 8];
            end else begin
               exp_mrd = ref_mem[ma[7:2]];
            end
            memp = 0;
         end
         if (busy && k == ack_at) busy = 0;
         check("rnd_if_rdata", b0.IF_RDATA, exp_ird);
         check("rnd_mem_rdata", b0.MEM_RDATA, exp_mrd);
         @(posedge CLK); #1;
      end
      b0.IF_REQ = 0; b0.MEM_REQ = 0;
      repeat (AC + 3) @(posedge CLK);
   endtask

   initial begin
      int   ack_cnt, both_cnt, last_ack, got;
      int   ack_c [4];
      bit   seq [7];
      bit   exp_seq [7];
      vec_t v;

      idle_inputs();
      vecs[0] = '{0, 0, 4'b0000, 32'h0000_0010, 32'h0,         1, 32'h1234_5678, 20'h00004, 4'b0000, 32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{1, 1, 4'b1011, 32'h0000_0102, 32'hABAB_ABAB, 1, 32'h1122_3344, 20'h00040, 4'b1011, 32'h11AB_3344, 32'h1234_5678};
      vecs[2] = '{1, 1, 4'b0000, 32'h0000_0200, 32'hDEAD_BEEF, 0, 32'h0,         20'h00080, 4'b0000, 32'hDEAD_BEEF, 32'h1234_5678};
      vecs[3] = '{1, 0, 4'b0000, 32'h0000_0200, 32'h0,         0, 32'h0,         20'h00080, 4'b0000, 32'hDEAD_BEEF, 32'h1234_5678};
      vecs[4] = '{0, 0, 4'b1010, 32'h0000_03FF, 32'h0,         1, 32'hCAFE_F00D, 20'h000FF, 4'b0000, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[5] = '{1, 0, 4'b0101, 32'h0000_0008, 32'h0,         1, 32'h0BAD_C0DE, 20'h00002, 4'b0101, 32'h0BAD_C0DE, 32'hCAFE_F00D};
      exp_seq = '{1, 1, 1, 1, 0, 1, 1};

      // Reset state
      #1 RST = 0;
      #2;
      check("rst_ce_n", b0.SRAM_CE_N, 1);
      check("rst_oe_n", b0.SRAM_OE_N, 1);
      check("rst_we_n", b0.SRAM_WE_N, 1);
      check("rst_be_n", b0.SRAM_BE_N, 4'hF);
      check("rst_addr", b0.SRAM_ADDR, 0);
      check("rst_dq_o", b0.SRAM_DQ_O, 0);
      check("rst_dq_oe", b0.SRAM_DQ_OE, 0);
      check("rst_acks", {b0.IF_ACK, b0.MEM_ACK}, 0);
      check("rst_rdata", {b0.IF_RDATA, b0.MEM_RDATA}, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Contention: both ports request continuously
      @(posedge CLK); #1;
      b0.IF_REQ = 1; b0.IF_ADDR = 32'h40; b0.MEM_REQ = 1; b0.MEM_WE = 0; b0.MEM_ADDR = 32'h80;
      got = 0; both_cnt = 0;
      for (int c = 0; c < 60 && got < 7; c++) begin
         @(negedge CLK);
         if (b0.IF_ACK && b0.MEM_ACK) both_cnt++;
         if (b0.MEM_ACK)     begin seq[got] = 1; got++; end
         else if (b0.IF_ACK) begin seq[got] = 0; got++; end
         @(posedge CLK); #1;
      end
      b0.IF_REQ = 0; b0.MEM_REQ = 0;
      check("cont_grants", got, 7);
      for (int i = 0; i < 7; i++) check($sformatf("cont_order_%0d", i), seq[i], exp_seq[i]);
      check("cont_both_ack", both_cnt, 0);
      repeat (AC + 3) @(posedge CLK);

      // ACCESS_CYCLES=1 instance: ack two cycles after REQ, then one every three cycles
      #1 pl1_en = 1; pl1_addr = 10'd1; pl1_dat = 32'h5A5A_0001;
      @(posedge CLK); #1;
      pl1_en = 0;
      b1.IF_REQ = 1; b1.IF_ADDR = 32'h0000_0004;
      ack_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge CLK);
         if (c == 1) check("ac1_addr", b1.SRAM_ADDR, 20'h00001);
         if (b1.IF_ACK && ack_cnt < 4) begin ack_c[ack_cnt] = c; ack_cnt++; end
         if (c == 2) check("ac1_rdata", b1.IF_RDATA, 32'h5A5A_0001);
         @(posedge CLK); #1;
      end
      b1.IF_REQ = 0;
      check("ac1_ack_count", ack_cnt >= 3, 1);
      if (ack_cnt >= 3) begin
         check("ac1_first_ack", ack_c[0], 2);
         check("ac1_period_1", ack_c[1] - ack_c[0], 3);
         check("ac1_period_2", ack_c[2] - ack_c[1], 3);
      end
      repeat (4) @(posedge CLK);

      // Reset in the second ACCESS cycle of a write
      #1;
      b0.MEM_REQ = 1; b0.MEM_WE = 1; b0.MEM_BE_N = 4'b0000;
      b0.MEM_ADDR = 32'h0000_0300; b0.MEM_WDATA = 32'h55AA_55AA;
      repeat (3) @(negedge CLK);
      check("rmw_we_active", b0.SRAM_WE_N, 0);
      #2 RST = 0;
      b0.MEM_REQ = 0;
      #1;
      check("rmw_we_n", b0.SRAM_WE_N, 1);
      check("rmw_ce_n", b0.SRAM_CE_N, 1);
      check("rmw_dq_oe", b0.SRAM_DQ_OE, 0);
      @(posedge CLK); #1;
      RST = 1;
      last_ack = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         if (b0.IF_ACK || b0.MEM_ACK || !b0.SRAM_CE_N) last_ack++;
      end
      check("rmw_quiet_after", last_ack, 0);
      v = '{0, 0, 4'b1111, 32'h0000_0310, 32'h0, 1, 32'h7777_8888, 20'h000C4, 4'b0000, 32'h7777_8888, 32'h7777_8888};
      run_vec(v);

      random_phase(800);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 32-bit external SRAM between the instruction-fetch port (read-only) and the MEM-stage port (read/write with byte enables).
- Sequences each access over a programmable number of cycles and drives the active-low SRAM control pins.
- Returns read data with a one-cycle ACK and raises per-port stall requests to the pipeline controller.
- Sits between the IF/MEM stages and the top-level SRAM pads.

Parameters:
- ACCESS_CYCLES, 2, cycles SRAM_CE_N/OE_N/WE_N are held active per access (legal range 1..15).
- STARVE_LIMIT, 4, consecutive MEM grants while IF is waiting, after which IF wins the next arbitration (legal range 1..15).
- SRAM_AW, 20, SRAM word-address width.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- IF_REQ  in  1  fetch request; held until IF_ACK
- IF_ADDR  in  32  fetch byte address (bits [1:0] ignored)
- IF_ACK  out  1  one-cycle pulse; IF_RDATA valid this cycle
- IF_RDATA  out  32  fetched word
- IF_STALL  out  1  IF_REQ & ~IF_ACK
- MEM_REQ  in  1  data request; held until MEM_ACK
- MEM_WE  in  1  1 = write, 0 = read
- MEM_BE_N  in  4  active-low byte enables (0000 = full word)
- MEM_ADDR  in  32  data byte address
- MEM_WDATA  in  32  write data (pre-replicated by the MEM stage)
- MEM_ACK  out  1  one-cycle completion pulse
- MEM_RDATA  out  32  read word (raw; the MEM stage extracts bytes)
- MEM_STALL  out  1  MEM_REQ & ~MEM_ACK
- SRAM_ADDR  out  SRAM_AW  word address = selected ADDR[SRAM_AW+1:2]
- SRAM_CE_N  out  1  chip enable, active low
- SRAM_OE_N  out  1  output enable, active low
- SRAM_WE_N  out  1  write enable, active low
- SRAM_BE_N  out  4  byte enables, active low
- SRAM_DQ_O  out  32  write data to pads
- SRAM_DQ_OE  out  1  1 = drive SRAM_DQ_O onto the bus
- SRAM_DQ_I  in  32  data from pads

Behaviour:
- Reset (RST=0, takes effect immediately and asynchronously):
  - State = IDLE; counters = 0; rdata register = 0.
  - SRAM_CE_N = OE_N = WE_N = 1; SRAM_BE_N = 4'b1111; SRAM_ADDR = 0; SRAM_DQ_O = 0; SRAM_DQ_OE = 0.
  - IF_ACK = MEM_ACK = 0; IF_RDATA = MEM_RDATA = 0.
  - An access in flight is abandoned. There is no ACK, and requesters re-issue after reset.
- FSM states: IDLE, ACCESS, DONE. The owner register (IF or MEM) and the cycle counter cnt are registered; all SRAM pins are driven from registers.
- IDLE:
  - If both requests are asserted, MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - The winner's address, BE, write data and write flag are latched. Next state = ACCESS, cnt = 0.
  - If there is no request, remain in IDLE with all pins inactive.
- starve_cnt:
  - Increments on each MEM grant while IF_REQ=1, saturating at STARVE_LIMIT.
  - Clears on an IF grant, or whenever IF_REQ=0 in IDLE.
- ACCESS:
  - CE_N = 0; SRAM_ADDR and SRAM_BE_N come from the latched values. An IF owner forces BE_N = 0000.
  - Read: OE_N = 0, WE_N = 1, DQ_OE = 0.
  - Write: OE_N = 1, WE_N = 0, DQ_OE = 1, DQ_O = latched write data.
  - cnt increments each cycle. On the edge where cnt == ACCESS_CYCLES-1:
    - For a read, SRAM_DQ_I is captured into the owner's rdata register.
    - Next state = DONE.
- DONE (exactly one cycle):
  - The owner's ACK = 1 and its RDATA is valid. For a write, RDATA is unchanged.
  - Write recovery: WE_N = 1, CE_N = 0, ADDR, BE_N and DQ_O are held, DQ_OE = 1.
  - Read: CE_N = 1, OE_N = 1.
  - REQ inputs are ignored in this cycle. Next state = IDLE.
- Latency:
  - From REQ sampled in IDLE to ACK = ACCESS_CYCLES+1 cycles.
  - Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- RDATA registers hold their last value until the next completed read on that port.
- Requester rules:
  - Inputs must stay stable while REQ=1 and ACK=0. The arbiter uses only the values latched at grant.
  - A REQ deasserted before ACK is a protocol violation. The access still completes and the ACK pulses.
- Simultaneous events:
  - A request arriving in the same cycle as another port's DONE is arbitrated in the following IDLE cycle.
  - The two ACKs are never asserted together.
- STALL outputs are combinational from REQ and ACK, so a stage stalls in the cycle of its REQ.

Test Plan:
- IF read only: after reset, IF_REQ=1, IF_ADDR=0x0000_0010, SRAM model returns 0x1234_5678.
  - Required: SRAM_ADDR=0x00004, OE_N low for 2 cycles, IF_ACK pulses on cycle 3 with IF_RDATA=0x1234_5678, IF_STALL=1 for cycles 0–2.
- MEM byte write: MEM_WE=1, MEM_BE_N=1011, MEM_ADDR=0x0000_0102, MEM_WDATA=0xABABABAB.
  - Required: WE_N low for exactly 2 cycles, then 1 recovery cycle with WE_N=1, CE_N=0 and data still driven.
  - Required: SRAM_BE_N=1011 throughout; the model updates only byte 2; MEM_ACK pulses on cycle 3.
- Contention and starvation: IF_REQ and MEM_REQ held continuously (STARVE_LIMIT=4).
  - Required grant order: MEM, MEM, MEM, MEM, IF, MEM, ...
  - Required: no cycle has both ACKs asserted.
- ACCESS_CYCLES=1 rebuild: read at 0x0000_0004 → ACK 2 cycles after REQ; back-to-back reads complete every 3 cycles.
- Reset mid-write: RST low during the second ACCESS cycle of a write.
  - Required: WE_N, CE_N and DQ_OE go inactive in the same cycle, without waiting for CLK.
  - Required: no ACK; state is IDLE after RST returns high.
- Read after write: write 0xDEADBEEF (BE_N=0000) to 0x0000_0200, then read it back.
  - Required: MEM_RDATA=0xDEADBEEF; IF_RDATA is unchanged throughout.
